// File: rtl/video_fetch_scheduler_if.sv
// Burst request channel between the fetch scheduler and the frame-buffer reader.
// The scheduler owns valid/address/markers; the reader answers with ready.
interface video_fetch_scheduler_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_sof;
  logic              req_eol;

  modport master (
    output req_valid, req_addr, req_sof, req_eol,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_sof, req_eol,
    output req_ready
  );
endinterface

// File: rtl/video_fetch_scheduler.sv
// Frame-buffer fetch scheduler: one frame of fixed-length burst requests per vblank,
// paced by a pixel-FIFO credit budget, with underrun and late-frame reporting.
module video_fetch_scheduler #(
  parameter int ADDR_W     = 32,
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int BURST_PIX  = 256,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     fb_base,
  input  logic [15:0]           fb_stride,
  input  logic                  vblank,
  input  logic                  pix_demand,
  input  logic                  data_pushed,
  video_fetch_scheduler_if.master req,
  output logic                  pix_avail,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun,
  input  logic                  underrun_clr
);
  localparam int BPL     = H_ACTIVE / BURST_PIX;
  localparam int BURST_W = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int LINE_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [BURST_W-1:0] LAST_BURST  = BURST_W'(BPL - 1);
  localparam logic [LINE_W-1:0]  LAST_LINE   = LINE_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0]  BURST_BYTES = ADDR_W'(BURST_PIX * 2);
  localparam logic [CNT_W-1:0]   CNT_BURST   = CNT_W'(BURST_PIX);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    FETCH   = 2'd2
  } state_t;

  state_t             state_r;
  logic [ADDR_W-1:0]  line_addr_r;
  logic [LINE_W-1:0]  line_r;
  logic [BURST_W-1:0] burst_r;
  logic [CNT_W-1:0]   alloc_r;
  logic [CNT_W-1:0]   deliv_r;
  logic               vblank_d_r;
  logic               restart_pend_r;
  logic               req_valid_r;
  logic [ADDR_W-1:0]  req_addr_r;
  logic               req_sof_r;
  logic               req_eol_r;
  logic               pix_avail_r;
  logic               busy_r;
  logic               frame_done_r;
  logic               underrun_r;

  logic               hs_s;
  logic               vb_rise_s;
  logic               late_s;
  logic               consume_s;
  logic               starve_s;
  logic               last_burst_s;
  logic               last_req_s;
  logic               credit_ok_s;
  logic [CNT_W-1:0]   alloc_nxt_s;
  logic [CNT_W-1:0]   deliv_nxt_s;

  assign hs_s         = req_valid_r & req.req_ready;
  assign vb_rise_s    = vblank & ~vblank_d_r;
  assign late_s       = (state_r == FETCH) & vb_rise_s;
  assign consume_s    = pix_demand & (deliv_r != CNT_ZERO);
  assign starve_s     = pix_demand & (deliv_r == CNT_ZERO);
  assign last_burst_s = (burst_r == LAST_BURST);
  assign last_req_s   = last_burst_s & (line_r == LAST_LINE);
  assign credit_ok_s  = (32'(alloc_r) + 32'(BURST_PIX)) <= 32'(FIFO_DEPTH);

  // Next values of the credit and delivered-pixel counters.
  always_comb begin
    alloc_nxt_s = alloc_r + (hs_s ? CNT_BURST : CNT_ZERO) - (consume_s ? CNT_ONE : CNT_ZERO);
    deliv_nxt_s = deliv_r + (data_pushed ? CNT_ONE : CNT_ZERO) - (consume_s ? CNT_ONE : CNT_ZERO);
  end

  // Counters, vblank edge history and the status flags seen by the display side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_r      <= CNT_ZERO;
      deliv_r      <= CNT_ZERO;
      pix_avail_r  <= 1'b0;
      vblank_d_r   <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      alloc_r      <= alloc_nxt_s;
      deliv_r      <= deliv_nxt_s;
      pix_avail_r  <= (deliv_nxt_s != CNT_ZERO);
      vblank_d_r   <= vblank;
      frame_done_r <= hs_s & last_req_s;
      if (starve_s || late_s) begin
        underrun_r <= 1'b1;
      end else if (underrun_clr) begin
        underrun_r <= 1'b0;
      end
    end
  end

  // Scheduler FSM with the registered request channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      line_addr_r    <= {ADDR_W{1'b0}};
      line_r         <= {LINE_W{1'b0}};
      burst_r        <= {BURST_W{1'b0}};
      restart_pend_r <= 1'b0;
      req_valid_r    <= 1'b0;
      req_addr_r     <= {ADDR_W{1'b0}};
      req_sof_r      <= 1'b0;
      req_eol_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r <= WAIT_VB;
          end
        end
        WAIT_VB: begin
          if (!enable) begin
            state_r <= IDLE;
          end else if (vb_rise_s) begin
            state_r     <= FETCH;
            busy_r      <= 1'b1;
            line_addr_r <= fb_base;
            line_r      <= {LINE_W{1'b0}};
            burst_r     <= {BURST_W{1'b0}};
          end
        end
        FETCH: begin
          if (!enable && (!req_valid_r || hs_s)) begin
            state_r        <= IDLE;
            busy_r         <= 1'b0;
            req_valid_r    <= 1'b0;
            restart_pend_r <= 1'b0;
          end else if ((late_s && (!req_valid_r || hs_s)) || (restart_pend_r && hs_s)) begin
            // Late frame: abandon the current frame and start over from the new base.
            line_addr_r    <= fb_base;
            line_r         <= {LINE_W{1'b0}};
            burst_r        <= {BURST_W{1'b0}};
            restart_pend_r <= 1'b0;
            req_valid_r    <= 1'b0;
          end else begin
            if (late_s) begin
              restart_pend_r <= 1'b1;
            end
            if (hs_s) begin
              req_valid_r <= 1'b0;
              if (last_req_s) begin
                state_r <= WAIT_VB;
                busy_r  <= 1'b0;
              end else if (last_burst_s) begin
                burst_r     <= {BURST_W{1'b0}};
                line_r      <= line_r + LINE_W'(1);
                line_addr_r <= line_addr_r + ADDR_W'(fb_stride);
              end else begin
                burst_r <= burst_r + BURST_W'(1);
              end
            end else if (!req_valid_r && enable && !restart_pend_r && credit_ok_s) begin
              req_valid_r <= 1'b1;
              req_addr_r  <= line_addr_r + ADDR_W'(burst_r) * BURST_BYTES;
              req_sof_r   <= (line_r == {LINE_W{1'b0}}) && (burst_r == {BURST_W{1'b0}});
              req_eol_r   <= last_burst_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req.req_valid = req_valid_r;
  assign req.req_addr  = req_addr_r;
  assign req.req_sof   = req_sof_r;
  assign req.req_eol   = req_eol_r;
  assign pix_avail     = pix_avail_r;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;
  assign underrun      = underrun_r;
endmodule

// File: tb/tb_video_fetch_scheduler.sv
// Directed bench for video_fetch_scheduler: a table of expected frame requests plus
// hand-written sequences for reset, underrun, credit stall, late frame and disable.
module tb_video_fetch_scheduler;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [ADDR_W-1:0] fb_base;
  logic [15:0]       fb_stride;
  logic              vblank;
  logic              pix_demand;
  logic              data_pushed;
  logic              pix_avail;
  logic              busy;
  logic              frame_done;
  logic              underrun;
  logic              underrun_clr;

  logic auto_mode;
  logic auto_dem;
  logic man_dem;
  logic push_en;
  int   granted;
  int   pushed;
  int   vectors;
  int   miscompares;

  typedef struct {
    int          ready_wait;
    logic [31:0] addr;
    logic        sof;
    logic        eol;
  } vec_t;

  vec_t vecs [16];

  video_fetch_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  video_fetch_scheduler #(
    .ADDR_W(ADDR_W), .H_ACTIVE(1024), .V_ACTIVE(4), .BURST_PIX(256), .FIFO_DEPTH(2048)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fb_base(fb_base),
    .fb_stride(fb_stride), .vblank(vblank), .pix_demand(pix_demand),
    .data_pushed(data_pushed), .req(bus), .pix_avail(pix_avail), .busy(busy),
    .frame_done(frame_done), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  assign pix_demand = auto_mode ? auto_dem : man_dem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reader model: one pixel pushed per cycle for every granted burst; in auto mode
  // the display pulls each pixel the cycle after it lands.
  initial begin
    data_pushed = 1'b0;
    auto_dem    = 1'b0;
    pushed      = 0;
    forever begin
      @(negedge clk);
      auto_dem = data_pushed;
      if (push_en && pushed < granted) begin
        data_pushed = 1'b1;
        pushed++;
      end else begin
        data_pushed = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, input string nm);
    int n;
    n = 0;
    while (bus.req_valid !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(bus.req_valid), 64'd1);
  endtask

  initial begin
    int hs_cnt;
    int n;
    logic seen;
    vectors = 0; miscompares = 0; granted = 0;
    auto_mode = 1'b0; man_dem = 1'b0; push_en = 1'b0;
    reset_n = 1'b0; enable = 1'b0; fb_base = 32'h1000_0000; fb_stride = 16'd2048;
    vblank = 1'b0; underrun_clr = 1'b0; bus.req_ready = 1'b0;

    vecs[0]  = '{0, 32'h1000_0000, 1'b1, 1'b0};
    vecs[1]  = '{2, 32'h1000_0200, 1'b0, 1'b0};
    vecs[2]  = '{0, 32'h1000_0400, 1'b0, 1'b0};
    vecs[3]  = '{1, 32'h1000_0600, 1'b0, 1'b1};
    vecs[4]  = '{0, 32'h1000_0800, 1'b0, 1'b0};
    vecs[5]  = '{0, 32'h1000_0A00, 1'b0, 1'b0};
    vecs[6]  = '{3, 32'h1000_0C00, 1'b0, 1'b0};
    vecs[7]  = '{0, 32'h1000_0E00, 1'b0, 1'b1};
    vecs[8]  = '{1, 32'h1000_1000, 1'b0, 1'b0};
    vecs[9]  = '{0, 32'h1000_1200, 1'b0, 1'b0};
    vecs[10] = '{0, 32'h1000_1400, 1'b0, 1'b0};
    vecs[11] = '{0, 32'h1000_1600, 1'b0, 1'b1};
    vecs[12] = '{2, 32'h1000_1800, 1'b0, 1'b0};
    vecs[13] = '{0, 32'h1000_1A00, 1'b0, 1'b0};
    vecs[14] = '{0, 32'h1000_1C00, 1'b0, 1'b0};
    vecs[15] = '{1, 32'h1000_1E00, 1'b0, 1'b1};

    // Reset held with random inputs.
    repeat (4) begin
      @(negedge clk);
      enable = 1'($urandom_range(0, 1)); vblank = 1'($urandom_range(0, 1));
      man_dem = 1'($urandom_range(0, 1)); underrun_clr = 1'($urandom_range(0, 1));
      bus.req_ready = 1'($urandom_range(0, 1)); fb_base = $urandom;
    end
    chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
    chk("rst_req_addr", 64'(bus.req_addr), 64'd0);
    chk("rst_req_sof", 64'(bus.req_sof), 64'd0);
    chk("rst_req_eol", 64'(bus.req_eol), 64'd0);
    chk("rst_pix_avail", 64'(pix_avail), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    enable = 1'b0; vblank = 1'b0; man_dem = 1'b0; underrun_clr = 1'b0;
    bus.req_ready = 1'b0; fb_base = 32'h1000_0000;
    @(negedge clk);
    reset_n = 1'b1;

    // Underrun: starve sets, simultaneous clear loses, lone clear wins.
    @(negedge clk); man_dem = 1'b1;
    @(negedge clk); man_dem = 1'b0;
    chk("underrun_set", 64'(underrun), 64'd1);
    chk("underrun_deliv_kept", 64'(pix_avail), 64'd0);
    man_dem = 1'b1; underrun_clr = 1'b1;
    @(negedge clk); man_dem = 1'b0; underrun_clr = 1'b0;
    chk("underrun_set_wins", 64'(underrun), 64'd1);
    underrun_clr = 1'b1;
    @(negedge clk); underrun_clr = 1'b0;
    chk("underrun_clear", 64'(underrun), 64'd0);
    chk("underrun_deliv_zero", 64'(pix_avail), 64'd0);

    // Enable mid-vblank: must wait for a fresh rising edge.
    vblank = 1'b1; enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("midvb_busy", 64'(busy), 64'd0);
    chk("midvb_valid", 64'(bus.req_valid), 64'd0);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    push_en = 1'b1; auto_mode = 1'b1; vblank = 1'b1;
    @(negedge clk); vblank = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_no_valid_yet", 64'(bus.req_valid), 64'd0);
    @(negedge clk);
    chk("first_req_latency", 64'(bus.req_valid), 64'd1);

    // Full frame from the expected-request table.
    for (int i = 0; i < 16; i++) begin
      wait_valid(1000, "frame_req_valid");
      chk("frame_addr", 64'(bus.req_addr), 64'(vecs[i].addr));
      chk("frame_sof", 64'(bus.req_sof), 64'(vecs[i].sof));
      chk("frame_eol", 64'(bus.req_eol), 64'(vecs[i].eol));
      for (int w = 0; w < vecs[i].ready_wait; w++) begin
        @(negedge clk);
        chk("frame_addr_hold", 64'(bus.req_addr), 64'(vecs[i].addr));
        chk("frame_valid_hold", 64'(bus.req_valid), 64'd1);
      end
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready = 1'b0;
      granted += 256;
      chk("frame_gap", 64'(bus.req_valid), 64'd0);
      chk("frame_done", 64'(frame_done), 64'(i == 15));
    end
    @(negedge clk);
    chk("frame_done_one_cycle", 64'(frame_done), 64'd0);
    chk("frame_end_busy", 64'(busy), 64'd0);
    n = 0;
    while (pushed < granted && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_pix_avail", 64'(pix_avail), 64'd0);

    // Credit stall: no consumption, exactly eight bursts fit the FIFO.
    auto_mode = 1'b0; man_dem = 1'b0; hs_cnt = 0;
    vblank = 1'b1; bus.req_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      vblank = 1'b0;
      if (bus.req_valid && bus.req_ready) begin
        hs_cnt++;
        granted += 256;
      end
    end
    chk("credit_count", 64'(hs_cnt), 64'd8);
    chk("credit_stalled", 64'(bus.req_valid), 64'd0);
    bus.req_ready = 1'b0;
    seen = 1'b0; n = 0;
    while (pushed < 512 && n < 2000) begin
      @(negedge clk);
      if (bus.req_valid) seen = 1'b1;
      n++;
    end
    chk("credit_pix_avail", 64'(pix_avail), 64'd1);
    repeat (256) begin
      @(negedge clk);
      man_dem = 1'b1;
      if (bus.req_valid) seen = 1'b1;
    end
    @(negedge clk);
    man_dem = 1'b0;
    chk("credit_no_early", 64'(seen), 64'd0);
    chk("credit_exact", 64'(bus.req_valid), 64'd0);
    n = 0;
    while (!bus.req_valid && n < 3) begin
      @(negedge clk);
      n++;
    end
    chk("credit_release", 64'(bus.req_valid), 64'd1);
    chk("credit_addr", 64'(bus.req_addr), 64'h1000_1000);
    chk("credit_sof", 64'(bus.req_sof), 64'd0);
    chk("credit_eol", 64'(bus.req_eol), 64'd0);

    // Late frame: vblank edge while a request is pending and not granted.
    chk("late_pre_underrun", 64'(underrun), 64'd0);
    fb_base = 32'h2000_0000; vblank = 1'b1;
    @(negedge clk); vblank = 1'b0;
    chk("late_underrun", 64'(underrun), 64'd1);
    chk("late_valid_held", 64'(bus.req_valid), 64'd1);
    chk("late_addr_held", 64'(bus.req_addr), 64'h1000_1000);
    @(negedge clk);
    chk("late_addr_held2", 64'(bus.req_addr), 64'h1000_1000);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    granted += 256;
    chk("late_gap", 64'(bus.req_valid), 64'd0);
    man_dem = 1'b1;
    wait_valid(1000, "late_next_valid");
    man_dem = 1'b0;
    chk("late_next_addr", 64'(bus.req_addr), 64'h2000_0000);
    chk("late_next_sof", 64'(bus.req_sof), 64'd1);
    chk("late_next_underrun", 64'(underrun), 64'd1);

    // Disable with a pending request: finish it, go idle, resume on next vblank edge.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_valid_held", 64'(bus.req_valid), 64'd1);
    chk("dis_busy_held", 64'(busy), 64'd1);
    chk("dis_addr_held", 64'(bus.req_addr), 64'h2000_0000);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    granted += 256;
    chk("dis_idle_busy", 64'(busy), 64'd0);
    chk("dis_idle_valid", 64'(bus.req_valid), 64'd0);
    enable = 1'b1; fb_base = 32'h3000_0000;
    repeat (5) @(negedge clk);
    chk("reen_wait_busy", 64'(busy), 64'd0);
    chk("reen_wait_valid", 64'(bus.req_valid), 64'd0);
    vblank = 1'b1;
    @(negedge clk); vblank = 1'b0;
    chk("reen_busy", 64'(busy), 64'd1);
    man_dem = 1'b1;
    wait_valid(1000, "reen_valid");
    man_dem = 1'b0;
    chk("reen_addr", 64'(bus.req_addr), 64'h3000_0000);
    chk("reen_sof", 64'(bus.req_sof), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/video_fetch_scheduler.md
# video_fetch_scheduler

Frame-buffer fetch scheduler in front of the AXI-Stream-to-video-out stage. It issues fixed-length burst read requests to the frame-buffer reader, one frame per vertical blank. It paces requests against a pixel-FIFO credit budget and tracks FIFO fill from push and pop events. It also reports underrun and frame-late conditions to the display side.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE, 768, active lines per frame
- BURST_PIX, 256, pixels per request; H_ACTIVE must be a multiple of BURST_PIX
- FIFO_DEPTH, 2048, downstream pixel FIFO depth in pixels (16-bit RGB565)

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scheduler run enable
- fb_base  in  ADDR_W  frame base byte address; sampled at frame start
- fb_stride  in  16  line pitch in bytes
- vblank  in  1  vertical blank from the timing generator
- pix_demand  in  1  display wants a pixel this cycle (sink tready)
- data_pushed  in  1  reader wrote one pixel into the FIFO
- req_valid  out  1  burst request valid
- req_ready  in  1  reader accepts request
- req_addr  out  ADDR_W  burst start byte address
- req_sof  out  1  first burst of the frame
- req_eol  out  1  last burst of a line
- pix_avail  out  1  FIFO holds at least one delivered pixel
- busy  out  1  state is FETCH
- frame_done  out  1  one-cycle pulse: last request of the frame accepted
- underrun  out  1  sticky error flag
- underrun_clr  in  1  clears underrun

## Operation
- States: IDLE, WAIT_VB, FETCH.
  - IDLE -> WAIT_VB when enable=1.
  - WAIT_VB -> FETCH on a vblank rising edge (vblank=1, registered vblank_d=0). On entry: latch fb_base into line_addr, line=0, burst=0.
  - FETCH -> WAIT_VB on the handshake of burst (H_ACTIVE/BURST_PIX-1) of line V_ACTIVE-1; pulse frame_done in the same transition.
  - Any state -> IDLE when enable=0 and no request is pending (req_valid=0, or handshake in this cycle).
- Request generation:
  - req_addr = line_addr + burst*BURST_PIX*2, modulo 2^ADDR_W.
  - At end of line: line_addr += fb_stride and burst=0.
  - req_sof=1 only for line 0 burst 0; req_eol=1 when burst = H_ACTIVE/BURST_PIX-1.
- Handshake: req_valid, req_addr, req_sof and req_eol are registered and held stable until req_valid&req_ready. After each handshake req_valid is low for at least one cycle.
- Credit counter `alloc` (width clog2(FIFO_DEPTH+1)):
  - +BURST_PIX on handshake, -1 on consume, net +BURST_PIX-1 when both occur.
  - req_valid may rise only in FETCH, with no restart pending and alloc+BURST_PIX <= FIFO_DEPTH.
- Delivered counter `deliv`:
  - +1 on data_pushed, -1 on consume, unchanged when both occur.
  - pix_avail = (deliv != 0), registered.
- Consume and underrun:
  - consume = pix_demand & (deliv != 0).
  - pix_demand with deliv==0 sets underrun and changes no counter.
- Late frame: a vblank rising edge while in FETCH sets underrun and schedules a restart.
  - If no request is pending, restart immediately.
  - If a request is pending, restart after its handshake; the next request then has req_sof=1 and addr = new fb_base.
- underrun_clr clears underrun. A set and a clear in the same cycle: set wins.
- Disabling does not clear alloc or deliv; only reset clears them.

## Timing
- Reset values: state IDLE; req_valid=0, req_addr=0, req_sof=0, req_eol=0, pix_avail=0, busy=0, frame_done=0, underrun=0; alloc=deliv=vblank_d=0.
- Frame start: vblank edge sampled at clock edge k -> FETCH at edge k. The first req_valid is high after edge k+1, if credit allows.
- The maximum issue rate is one request per two cycles.
- Counter updates on a handshake or consume in cycle n are visible to the credit check and pix_avail after edge n+1.
- frame_done is high for exactly the cycle after the final handshake.
- A first frame begins only at a vblank edge seen after enable; enabling in mid-vblank waits for the next edge.

## Test plan
- Reset: hold reset_n=0 with random inputs -> every output at its reset value. Release with enable=1 -> no req_valid until a vblank rising edge.
- Full frame: fb_base=0x1000_0000, fb_stride=2048, req_ready=1, each grant answered by 256 data_pushed and matching pix_demand.
  - Expect 3072 requests: first addr 0x1000_0000 with sof=1; 2nd addr 0x1000_0200; 5th addr 0x1000_0800 with sof=0.
  - eol=1 on every 4th request; frame_done pulses once.
- Credit stall: req_ready=1, data_pushed streamed, pix_demand=0.
  - Exactly 8 requests are issued, then req_valid stays low.
  - After 256 consumes, the 9th request issues within 3 cycles.
- Underrun: pix_demand=1 with deliv=0 -> underrun=1 and deliv unchanged.
  - underrun_clr in the same cycle as a new underrun -> underrun stays 1.
  - A lone clear -> underrun=0.
- Late frame: vblank edge in FETCH while req_valid=1 and req_ready=0.
  - req_addr is held stable until the grant.
  - The next request has sof=1, addr = new fb_base, and underrun=1.
- Disable mid-frame: enable=0 while a request is pending -> request completes, then state IDLE, busy=0. Re-enable -> fetch resumes only after the next vblank edge.
